// File: rtl/adder_pipe_arbiter_if.sv
// Requester, result and shared-adder signals of adder_pipe_arbiter grouped as one bundle.
// slave = arbiter side, master = requesters, result sinks and adder model.
interface adder_pipe_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res0_valid;
  logic [WIDTH:0]   res0_sum;
  logic             res1_valid;
  logic [WIDTH:0]   res1_sum;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_s, add_cout,
    output req0_ready, req1_ready,
    output res0_valid, res0_sum, res1_valid, res1_sum,
    output add_a, add_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_s, add_cout,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_sum, res1_valid, res1_sum,
    input  add_a, add_b, busy
  );
endinterface

// File: rtl/adder_pipe_arbiter.sv
// Two-requester arbiter for a shared LATENCY-deep adder; round-robin ties, ADDER_ARB_FIXED_PRIO_EN gives req0 fixed priority.
// Handshake to resN_valid is LATENCY+1 edges, one op/cycle; ready is combinational from grant, results have no backpressure.
module adder_pipe_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_pipe_arbiter_if.slave  io
);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic             gnt0;
  logic             gnt1;
  logic             hs;

  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;

  tag_t             tag_q [LATENCY];
  tag_t             tag_d [LATENCY];
  tag_t             tag_x_q, tag_x_d;

  logic             res0_valid_q, res0_valid_d;
  logic             res1_valid_q, res1_valid_d;
  logic [WIDTH:0]   res0_sum_q, res0_sum_d;
  logic [WIDTH:0]   res1_sum_q, res1_sum_d;

  logic             busy;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic             last1_q, last1_d;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    gnt0 = io.req0_valid;
    gnt1 = io.req1_valid & ~io.req0_valid;
`else
    // On a tie the requester that did not win last time gets the grant.
    gnt0 = io.req0_valid & (~io.req1_valid | last1_q);
    gnt1 = io.req1_valid & (~io.req0_valid | ~last1_q);
`endif
  end

  assign io.req0_ready = gnt0 & rst_n;
  assign io.req1_ready = gnt1 & rst_n;
  assign hs            = io.req0_ready | io.req1_ready;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    last1_d = last1_q;
    if (hs) last1_d = io.req1_ready;
  end
`endif

  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (io.req0_ready) begin
      add_a_d = io.req0_a;
      add_b_d = io.req0_b;
    end else if (io.req1_ready) begin
      add_a_d = io.req1_a;
      add_b_d = io.req1_b;
    end
  end

  // The extra exit slot lines the tag up with the adder output one edge
  // after the operands have spent LATENCY edges inside the adder.
  always_comb begin
    tag_d[0].vld = hs;
    tag_d[0].id  = io.req1_ready;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_x_d = tag_q[LATENCY-1];
  end

  always_comb begin
    res0_valid_d = tag_x_q.vld & ~tag_x_q.id;
    res1_valid_d = tag_x_q.vld &  tag_x_q.id;
    res0_sum_d   = res0_sum_q;
    res1_sum_d   = res1_sum_q;
    if (res0_valid_d) res0_sum_d = {io.add_cout, io.add_s};
    if (res1_valid_d) res1_sum_d = {io.add_cout, io.add_s};
  end

  always_comb begin
    busy = tag_x_q.vld | res0_valid_q | res1_valid_q;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_q      <= '0;
      add_b_q      <= '0;
      tag_x_q      <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      res0_sum_q   <= '0;
      res1_sum_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      tag_x_q      <= tag_x_d;
      res0_valid_q <= res0_valid_d;
      res1_valid_q <= res1_valid_d;
      res0_sum_q   <= res0_sum_d;
      res1_sum_q   <= res1_sum_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

`ifndef ADDER_ARB_FIXED_PRIO_EN
  // Reset points at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last1_q <= 1'b1;
    else        last1_q <= last1_d;
  end
`endif

  assign io.add_a      = add_a_q;
  assign io.add_b      = add_b_q;
  assign io.res0_valid = res0_valid_q;
  assign io.res1_valid = res1_valid_q;
  assign io.res0_sum   = res0_sum_q;
  assign io.res1_sum   = res1_sum_q;
  assign io.busy       = busy;

endmodule

// File: doc/adder_pipe_arbiter.md
ADDER_PIPE_ARBITER -- requirements
Module: adder_pipe_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width of the shared pipelined adder.
REQ-002 SHALL have parameter LATENCY, default 5, pipeline depth (clock edges) of the shared adder.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester operand valid.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  operand accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  requester operands.
REQ-008 SHALL have ports res0_valid / res1_valid  output  1  one-cycle result strobe per requester.
REQ-009 SHALL have ports res0_sum / res1_sum  output  WIDTH+1  result {carry-out, sum}.
REQ-010 SHALL have ports add_a, add_b  output  WIDTH  registered operands driven to the shared adder.
REQ-011 SHALL have ports add_s  input  WIDTH and add_cout  input  1  adder sum and carry-out.
REQ-012 SHALL have port busy  output  1  high while any accepted operation is still in flight.

Function
REQ-013 Handshake SHALL occur on a rising edge where reqN_valid and reqN_ready are both high; at most one requester SHALL be ready per cycle.
REQ-014 reqN_ready SHALL be combinational: high only for the granted requester, low for both when neither is valid.
REQ-015 Single valid requester SHALL be granted immediately; when both valid, grant SHALL go to the requester not granted last (round-robin), then the last-granted pointer SHALL update on the handshake edge only.
REQ-016 On handshake edge E, add_a/add_b SHALL load the granted operands; with no handshake they SHALL hold their value.
REQ-017 A LATENCY-deep tag pipeline SHALL shift {valid, requester id} every edge, loading {1,id} on handshake and {0,x} otherwise.
REQ-018 When the tag exits at edge E+LATENCY, edge E+LATENCY+1 SHALL register {add_cout, add_s} into resN_sum of the tagged requester and pulse resN_valid for exactly one cycle.
REQ-019 Total latency SHALL be LATENCY+1 edges from handshake to resN_valid; throughput one operation per cycle across both requesters, back-to-back without bubbles.
REQ-020 Results SHALL return in issue order; resN_sum SHALL hold its last value while resN_valid is low; there is no result backpressure.
REQ-021 Both res0_valid and res1_valid SHALL never be high in the same cycle.
REQ-022 busy SHALL equal the OR of all tag-pipeline valid bits and the output-stage valid.
REQ-023 Sum SHALL be modulo 2^(WIDTH+1) with no overflow flag; carry-out is bit WIDTH.

Reset
REQ-024 rst_n low SHALL asynchronously clear: tags, res0/1_valid, res0/1_sum, add_a, add_b, busy to 0; round-robin pointer to "last granted = requester 1" (requester 0 wins first tie).
REQ-025 Reset mid-operation SHALL discard all in-flight operations; no resN_valid SHALL assert after deassertion until LATENCY+1 edges after a new handshake.
REQ-026 reqN_ready SHALL be low while rst_n is low.

Configuration
REQ-027 With ADDER_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win a tie and the pointer SHALL be unused; without it, round-robin per REQ-015.

Verification
REQ-028 Single op, LATENCY=5: req0 A=0xF6B9EC29, B=0xF0FFF00F handshake at edge E -> res0_valid one cycle after edge E+6, res0_sum=0x1E7B9DC38, res1_valid stays 0.
REQ-029 Contention: both valid continuously, req0 {0x34CF36CD,0x9C8F0C6B}, req1 {1,1} -> grants alternate 0,1,0,1; res0_sum=0x0D15E4338 and res1_sum=0x000000002 alternate every cycle, no bubbles.
REQ-030 Same as REQ-029 with ADDER_ARB_FIXED_PRIO_EN -> req1_ready stays 0, only res0_valid pulses, every cycle.
REQ-031 Wrap: req1 0xFFFFFFFF+0x00000001 -> res1_sum=0x100000000; 0xFFFFFFFF+0xFFFFFFFF -> 0x1FFFFFFFE.
REQ-032 Reset mid-flight: three ops issued, rst_n pulsed low 2 edges later -> busy, res0/1_valid 0 immediately and no result pulses for 10 cycles after release with no new requests.
REQ-033 Idle: no valid for 20 cycles after reset -> both ready 0, busy 0, add_a/add_b remain 0.
